// File: rtl/ppr_pkg.sv
// Shared constants, list entry type and scan FSM state encoding for the
// PPR random-walk engine and its top-k scan stage.
package ppr_pkg;

  localparam int ADDR_WIDTH         = 13;
  localparam int DATA_WIDTH         = 32;
  localparam int NODE_WIDTH         = 16;
  localparam int NODE_NUM           = 100;
  localparam int SCORE_TABLE_OFFSET = 100;
  localparam int TOPK               = 8;   // legal range 1..32

  // Width of a valid-entry count (0..TOPK) and of a list index (0..TOPK-1).
  localparam int CNT_WIDTH = $clog2(TOPK + 1);
  localparam int IDX_WIDTH = (TOPK > 1) ? $clog2(TOPK) : 1;

  typedef struct packed {
    logic                  valid;
    logic [NODE_WIDTH-1:0] node;
    logic [DATA_WIDTH-1:0] score;
  } topk_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/ppr_topk_scan_if.sv
// Score-table read port plus result stream of the top-k scan stage.
// master = scan block side, slave = BRAM / consumer side.
interface ppr_topk_scan_if;

  logic                            o_rd_en;
  logic [ppr_pkg::ADDR_WIDTH-1:0]  o_rd_addr;
  logic [ppr_pkg::DATA_WIDTH-1:0]  i_rd_data;

  logic                            o_res_valid;
  logic                            i_res_ready;
  logic [ppr_pkg::NODE_WIDTH-1:0]  o_res_node;
  logic [ppr_pkg::DATA_WIDTH-1:0]  o_res_score;
  logic                            o_res_last;

  modport master (
    output o_rd_en, o_rd_addr,
    input  i_rd_data,
    output o_res_valid, o_res_node, o_res_score, o_res_last,
    input  i_res_ready
  );

  modport slave (
    input  o_rd_en, o_rd_addr,
    output i_rd_data,
    input  o_res_valid, o_res_node, o_res_score, o_res_last,
    output i_res_ready
  );

endinterface

// File: rtl/ppr_topk_insert.sv
// TOPK-deep sorted register list (highest score at index 0). One entry can
// be inserted per cycle with a parallel compare/shift; invalid slots always
// sit below valid ones, so the "displace" vector is a thermometer code.
module ppr_topk_insert
  import ppr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  ins_en_i,
  input  logic [NODE_WIDTH-1:0] ins_node_i,
  input  logic [DATA_WIDTH-1:0] ins_score_i,
  input  logic [IDX_WIDTH-1:0]  rd_idx_i,
  output topk_entry_t           rd_entry_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  topk_entry_t      list_q [TOPK];
  topk_entry_t      list_d [TOPK];
  topk_entry_t      new_entry;
  logic [TOPK-1:0]  displace;

  assign new_entry = '{valid: 1'b1, node: ins_node_i, score: ins_score_i};

  // Strictly-greater compare keeps an earlier equal-score node ahead.
  always_comb begin
    displace = '0;
    for (int j = 0; j < TOPK; j++) begin
      displace[j] = !list_q[j].valid || (ins_score_i > list_q[j].score);
    end
  end

  // Next list: first displaced slot takes the new entry, slots below shift down.
  always_comb begin
    for (int j = 0; j < TOPK; j++) begin
      list_d[j] = list_q[j];
    end
    if (clr_i) begin
      for (int j = 0; j < TOPK; j++) begin
        list_d[j] = '0;
      end
    end else if (ins_en_i) begin
      if (displace[0]) begin
        list_d[0] = new_entry;
      end
      for (int j = 1; j < TOPK; j++) begin
        if (displace[j]) begin
          list_d[j] = displace[j-1] ? list_q[j-1] : new_entry;
        end
      end
    end
  end

  // List registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < TOPK; j++) begin
        list_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < TOPK; j++) begin
        list_q[j] <= list_d[j];
      end
    end
  end

  // Number of valid entries.
  always_comb begin
    count_o = '0;
    for (int j = 0; j < TOPK; j++) begin
      if (list_q[j].valid) begin
        count_o = count_o + CNT_WIDTH'(1);
      end
    end
  end

  assign rd_entry_o = list_q[rd_idx_i];

endmodule

// File: rtl/ppr_topk_scan.sv
// Scans the score table for nodes 1..NODE_NUM, keeps the TOPK best in a
// sorted list and streams them out highest first.
// Optional feature macro: PPR_TOPK_SKIP_ZERO_EN -- when defined, zero scores
// (unvisited nodes) are never inserted into the list.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for i_start; clears list and loads node counter = 1
// SCAN     | one BRAM read per cycle; previous read's score is inserted
// DRAIN    | inserts the last returned score; skips EMIT if list is empty
// EMIT     | streams list entries 0..count-1 over valid/ready
// DONE     | one-cycle o_done pulse
module ppr_topk_scan
  import ppr_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  ppr_topk_scan_if.master   bus
);

  scan_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   rd_vld_q;
  logic [NODE_WIDTH-1:0]  node_q;

  logic                   clr;
  logic                   ins_en;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   res_valid;
  logic                   res_last;
  topk_entry_t            cur_entry;
  logic [CNT_WIDTH-1:0]   count;

`ifdef PPR_TOPK_SKIP_ZERO_EN
  assign ins_en = rd_vld_q && (bus.i_rd_data != '0);
`else
  assign ins_en = rd_vld_q;
`endif

  ppr_topk_insert u_list (
    .clk_i       (i_clk),
    .rst_n_i     (i_rst_n),
    .clr_i       (clr),
    .ins_en_i    (ins_en),
    .ins_node_i  (node_q),
    .ins_score_i (bus.i_rd_data),
    .rd_idx_i    (idx_q),
    .rd_entry_o  (cur_entry),
    .count_o     (count)
  );

  assign res_last = res_valid && (CNT_WIDTH'(idx_q) == (count - CNT_WIDTH'(1)));

  // Next-state and per-state outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    clr       = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          clr     = 1'b1;
          cnt_d   = ADDR_WIDTH'(1);
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        o_busy  = 1'b1;
        rd_en   = 1'b1;
        rd_addr = cnt_q + ADDR_WIDTH'(SCORE_TABLE_OFFSET);
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(NODE_NUM)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        // The final insert lands this cycle, so emptiness must account for it.
        if ((count == '0) && !ins_en) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        o_busy    = 1'b1;
        res_valid = 1'b1;
        if (bus.i_res_ready) begin
          if (res_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, node counter and emit index registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Tag each read with its node id so the score can be inserted next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_q <= 1'b0;
      node_q   <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) begin
        node_q <= NODE_WIDTH'(cnt_q);
      end
    end
  end

  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr   = rd_addr;
  assign bus.o_res_valid = res_valid;
  assign bus.o_res_node  = res_valid ? cur_entry.node  : '0;
  assign bus.o_res_score = res_valid ? cur_entry.score : '0;
  assign bus.o_res_last  = res_last;

endmodule

// File: tb/tb_ppr_topk_scan.sv
// Bench for ppr_topk_scan: BRAM model, vector table of score patterns and a
// scoreboard of expected beats built by a selection-sort reference model.
module tb_ppr_topk_scan;
  import ppr_pkg::*;

`ifdef PPR_TOPK_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  ppr_topk_scan_if bus ();

  ppr_topk_scan dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- BRAM model: data one cycle after the read strobe
  logic [DATA_WIDTH-1:0] mem [0:NODE_NUM];
  int                    bram_a;

  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      bram_a = int'(bus.o_rd_addr) - SCORE_TABLE_OFFSET;
      if (bram_a < 1 || bram_a > NODE_NUM) begin
        chk("rd_addr_range", longint'(bus.o_rd_addr), 0);
        bus.i_rd_data <= 32'hDEAD_BEEF;
      end else begin
        bus.i_rd_data <= mem[bram_a];
      end
    end
  end

  // ---------------- scoreboard
  typedef struct {
    logic [NODE_WIDTH-1:0] node;
    logic [DATA_WIDTH-1:0] score;
    logic                  last;
  } beat_t;

  beat_t exp_q [$];

  // Reference: repeatedly pick the highest remaining eligible score, lowest id on ties.
  task automatic build_expected();
    bit used [0:NODE_NUM];
    int pick [$];
    for (int n = 0; n <= NODE_NUM; n++) used[n] = 1'b0;
    for (int r = 0; r < TOPK; r++) begin
      int best;
      best = 0;
      for (int n = 1; n <= NODE_NUM; n++) begin
        if (!used[n] && (!SKIP || mem[n] != 0) && (best == 0 || mem[n] > mem[best]))
          best = n;
      end
      if (best == 0) break;
      used[best] = 1'b1;
      pick.push_back(best);
    end
    foreach (pick[i]) begin
      beat_t b;
      b.node  = NODE_WIDTH'(pick[i]);
      b.score = mem[pick[i]];
      b.last  = (i == pick.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  int    beats_seen = 0;
  int    done_seen  = 0;
  logic  stall_q    = 1'b0;
  beat_t held;

  // Monitor on the falling edge: handshakes, stall stability, done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (done) done_seen++;
      if (stall_q) begin
        chk("stall_valid", bus.o_res_valid, 1);
        chk("stall_node",  bus.o_res_node,  held.node);
        chk("stall_score", bus.o_res_score, held.score);
        chk("stall_last",  bus.o_res_last,  held.last);
      end
      if (bus.o_res_valid && bus.i_res_ready) begin
        beats_seen++;
        stall_q = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_node", bus.o_res_node, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_node",  bus.o_res_node,  e.node);
          chk("beat_score", bus.o_res_score, e.score);
          chk("beat_last",  bus.o_res_last,  e.last);
        end
      end else if (bus.o_res_valid) begin
        stall_q    = 1'b1;
        held.node  = bus.o_res_node;
        held.score = bus.o_res_score;
        held.last  = bus.o_res_last;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic fill(input int pat);
    for (int n = 0; n <= NODE_NUM; n++) begin
      case (pat)
        0:       mem[n] = DATA_WIDTH'(n);
        3:       mem[n] = DATA_WIDTH'($urandom_range(1, 40));
        4:       mem[n] = DATA_WIDTH'(NODE_NUM + 1 - n);
        default: mem[n] = '0;
      endcase
    end
    if (pat == 1) begin
      mem[7] = 5; mem[3] = 5; mem[50] = 5;
    end
    if (pat == 5) begin
      mem[1] = 9; mem[NODE_NUM] = 77;
    end
  endtask

  // One full operation; lat is cycles after S at which o_done is seen.
  task automatic run_op(input int rmode, input int exp_beats, input int exp_lat,
                        input bit xstart);
    int lat, done0, beats0;
    done0  = done_seen;
    beats0 = beats_seen;
    build_expected();
    @(posedge clk); #1;
    start = 1'b1;
    bus.i_res_ready = 1'b1;
    @(posedge clk); #1;                 // edge S has sampled start
    start = 1'b0;
    chk("busy_at_S1",   busy, 1);
    chk("rd_en_at_S1",  bus.o_rd_en, 1);
    chk("rd_addr_at_S1", bus.o_rd_addr, 1 + SCORE_TABLE_OFFSET);
    lat = -1;
    for (int n = 1; n < 2000; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      start = xstart && (n == 50 || n == 104);
      bus.i_res_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.i_res_ready = 1'b1;
    if (exp_lat >= 0) chk("done_latency", lat, exp_lat);
    else              chk("done_within_bound", (lat > 0), 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count",  done_seen - done0, 1);
    chk("beat_count",  beats_seen - beats0, exp_beats);
    chk("sb_drained",  exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    int pat;
    int rmode;
    int beats;
    int lat;
    bit xstart;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bus.i_res_ready = 1'b1;
    bus.i_rd_data   = '0;

    vecs[0] = '{0, 0, 8, NODE_NUM + 10, 1'b0};
    vecs[1] = SKIP ? '{1, 0, 3, NODE_NUM + 5, 1'b0} : '{1, 0, 8, NODE_NUM + 10, 1'b0};
    vecs[2] = SKIP ? '{2, 0, 0, NODE_NUM + 2, 1'b0} : '{2, 0, 8, NODE_NUM + 10, 1'b0};
    vecs[3] = '{3, 1, 8, -1, 1'b0};
    vecs[4] = '{4, 0, 8, NODE_NUM + 10, 1'b0};
    vecs[5] = SKIP ? '{5, 0, 2, NODE_NUM + 4, 1'b0} : '{5, 0, 8, NODE_NUM + 10, 1'b0};
    vecs[6] = '{0, 0, 8, NODE_NUM + 10, 1'b1};
    vecs[7] = '{3, 1, 8, -1, 1'b1};

    // Reset state
    #1;
    chk("rst_busy",      busy, 0);
    chk("rst_done",      done, 0);
    chk("rst_rd_en",     bus.o_rd_en, 0);
    chk("rst_rd_addr",   bus.o_rd_addr, 0);
    chk("rst_res_valid", bus.o_res_valid, 0);
    chk("rst_res_node",  bus.o_res_node, 0);
    chk("rst_res_score", bus.o_res_score, 0);
    chk("rst_res_last",  bus.o_res_last, 0);
    #24 rst_n = 1'b1;

    foreach (vecs[i]) begin
      fill(vecs[i].pat);
      run_op(vecs[i].rmode, vecs[i].beats, vecs[i].lat, vecs[i].xstart);
    end

    // Abort mid-SCAN with an asynchronous reset, then a clean rerun.
    fill(0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",      busy, 0);
    chk("abort_rd_en",     bus.o_rd_en, 0);
    chk("abort_rd_addr",   bus.o_rd_addr, 0);
    chk("abort_res_valid", bus.o_res_valid, 0);
    chk("abort_done",      done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_idle_busy", busy, 0);
    run_op(0, 8, NODE_NUM + 10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time bound in case the run stalls outside a bounded wait.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
